// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch stage: owns the PC, runs ibus req/ack, holds one instruction for IF/ID
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_data_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_o
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;
  localparam logic [1:0] S_DROP  = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pc_q;
  logic [31:0] r_inst_q;
  logic        r_valid_q;
  logic        r_req;
  logic [31:0] r_addr;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_q_nxt;
  logic [31:0] w_inst_q_nxt;
  logic        w_valid_nxt;
  logic        w_req_nxt;
  logic [31:0] w_addr_nxt;

  logic        w_consume;
  logic        w_slot_free;
  logic        w_ack;
  logic        w_unused;

  // Only stall[1] (IF/ID hold) concerns this stage.
  assign w_unused    = &{1'b0, stall[5:2], stall[0]};
  assign w_consume   = r_valid_q & ~stall[1];
  assign w_slot_free = ~r_valid_q | w_consume;
  assign w_ack       = ibus_ack_i & ((r_state == S_BUSY) | (r_state == S_DROP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_READY;
      S_READY: if (!branch_flag_i && w_slot_free) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (w_ack)              w_state_nxt = S_READY;
        else if (branch_flag_i) w_state_nxt = S_DROP;
      end
      S_DROP:  if (w_ack) w_state_nxt = S_READY;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    w_pc_nxt     = r_pc;
    w_pc_q_nxt   = r_pc_q;
    w_inst_q_nxt = r_inst_q;
    w_valid_nxt  = r_valid_q & ~w_consume;
    w_req_nxt    = r_req;
    w_addr_nxt   = r_addr;
    case (r_state)
      S_READY: begin
        if (!branch_flag_i && w_slot_free) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = r_pc;
        end
      end
      S_BUSY: begin
        if (w_ack) begin
          w_req_nxt = 1'b0;
          if (!branch_flag_i) begin
            w_valid_nxt  = 1'b1;
            w_pc_q_nxt   = r_addr;
            w_inst_q_nxt = ibus_data_i;
            w_pc_nxt     = r_pc + 32'(PC_STEP);
          end
        end
      end
      S_DROP: begin
        if (w_ack) w_req_nxt = 1'b0;
      end
      default: ;
    endcase
    // A taken branch flushes the held word and wins over consume and issue.
    if (branch_flag_i && (r_state != S_BOOT)) begin
      w_pc_nxt    = branch_target_i;
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc      <= RESET_PC;
      r_pc_q    <= 32'h0;
      r_inst_q  <= 32'h0;
      r_valid_q <= 1'b0;
      r_req     <= 1'b0;
      r_addr    <= 32'h0;
    end else begin
      r_pc      <= w_pc_nxt;
      r_pc_q    <= w_pc_q_nxt;
      r_inst_q  <= w_inst_q_nxt;
      r_valid_q <= w_valid_nxt;
      r_req     <= w_req_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  assign ibus_req_o  = r_req;
  assign ibus_addr_o = r_addr;
  assign if_pc       = r_valid_q ? r_pc_q   : 32'h0;
  assign if_inst     = r_valid_q ? r_inst_q : 32'h0;
  assign stallreq_o  = rst & ~r_valid_q & (r_state != S_BOOT);

endmodule
